// File: rtl/boot_fetch_core_if.sv
// boot_fetch_core_if: control, flash bus, tick outputs and decoder strobes of the fetch core
interface boot_fetch_core_if;
  logic        clk_enable;
  logic        lsi_enable;
  logic        lsi_clk;
  logic        wdt_clk;
  logic        we;
  logic        re;
  logic [23:0] addr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic [3:0]  opcode;
  logic [3:0]  alu_op;
  logic        pc_load;
  logic        ir_load;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  modport master (
    output clk_enable, lsi_enable, we, re, addr, din, opcode,
    input  lsi_clk, wdt_clk, dout, alu_op, pc_load, ir_load, mem_read, mem_write, reg_write
  );
  modport slave (
    input  clk_enable, lsi_enable, we, re, addr, din, opcode,
    output lsi_clk, wdt_clk, dout, alu_op, pc_load, ir_load, mem_read, mem_write, reg_write
  );
endinterface

// File: rtl/boot_fetch_core.sv
// boot_fetch_core: low-speed tick generator, byte-wide flash array and combinational opcode decoder
module boot_fetch_core #(
  parameter int DEPTH   = 4096,
  parameter int LSI_DIV = 4,
  parameter int WDT_DIV = 2
) (
  input logic              clk,
  input logic              reset,
  boot_fetch_core_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(LSI_DIV + 1);
  localparam int WW = $clog2(WDT_DIV + 1);
  // The array starts erased and is never touched by reset, like real flash.
  logic [7:0]    mem_q [DEPTH] = '{default: 8'hFF};
  logic [AW-1:0] idx;
  logic          wr_en;
  logic          rd_en;
  logic [7:0]    dout_d, dout_q;
  logic [LW-1:0] lsi_cnt_d, lsi_cnt_q;
  logic [WW-1:0] wdt_cnt_d, wdt_cnt_q;
  logic          lsi_d, lsi_q, wdt_d, wdt_q;
  logic          lsi_wrap, lsi_rise, wdt_wrap;
  logic [3:0]    op;
  logic          unused_addr_hi;
  assign unused_addr_hi = ^bus.addr[23:AW];
  always_comb begin
    idx    = bus.addr[AW-1:0];
    wr_en  = bus.clk_enable && bus.we;
    rd_en  = bus.clk_enable && !bus.we && bus.re;
    dout_d = rd_en ? mem_q[idx] : dout_q;
  end
  always_ff @(posedge clk) begin
    if (reset && wr_en) mem_q[idx] <= bus.din;
  end
  // The watchdog divider advances once per full lsi_clk period (on its rising toggle).
  always_comb begin
    lsi_wrap  = lsi_cnt_q == LW'(LSI_DIV - 1);
    lsi_cnt_d = (!bus.lsi_enable || lsi_wrap) ? '0 : lsi_cnt_q + 1'b1;
    lsi_d     = bus.lsi_enable && (lsi_q ^ lsi_wrap);
    lsi_rise  = bus.lsi_enable && lsi_wrap && !lsi_q;
    wdt_wrap  = wdt_cnt_q == WW'(WDT_DIV - 1);
    wdt_cnt_d = !bus.lsi_enable ? '0 : !lsi_rise ? wdt_cnt_q : wdt_wrap ? '0 : wdt_cnt_q + 1'b1;
    wdt_d     = bus.lsi_enable && (wdt_q ^ (lsi_rise && wdt_wrap));
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      dout_q    <= 8'h00;
      lsi_cnt_q <= '0;
      wdt_cnt_q <= '0;
      lsi_q     <= 1'b0;
      wdt_q     <= 1'b0;
    end else begin
      dout_q    <= dout_d;
      lsi_cnt_q <= lsi_cnt_d;
      wdt_cnt_q <= wdt_cnt_d;
      lsi_q     <= lsi_d;
      wdt_q     <= wdt_d;
    end
  end
  assign bus.dout    = dout_q;
  assign bus.lsi_clk = lsi_q;
  assign bus.wdt_clk = wdt_q;
  // ALU ops 0x2..0x7 map to opcode-1; reserved opcodes fall through as NOP.
  always_comb begin
    op            = bus.opcode;
    bus.alu_op    = !reset ? 4'h0 : (op inside {[4'h2:4'h7]}) ? op - 4'h1 : (op == 4'hC) ? 4'h1 : 4'h0;
    bus.reg_write = reset && (op inside {[4'h1:4'h9]});
    bus.mem_read  = reset && (op == 4'h9 || op == 4'hD);
    bus.mem_write = reset && op == 4'hA;
    bus.pc_load   = reset && (op == 4'hB || op == 4'hC);
    bus.ir_load   = reset && op == 4'hD;
  end
endmodule

// File: tb/tb_boot_fetch_core.sv
// tb_boot_fetch_core: directed and randomized checks of flash, ticks and decoder against a behavioural model
module tb_boot_fetch_core;
  localparam int DEPTH   = 4096;
  localparam int LSI_DIV = 4;
  localparam int WDT_DIV = 2;
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  boot_fetch_core_if bus ();
  boot_fetch_core #(.DEPTH(DEPTH), .LSI_DIV(LSI_DIV), .WDT_DIV(WDT_DIV)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );
  logic [7:0] ref_mem [DEPTH];
  logic [7:0] m_dout = 8'h00;
  int n_en    = 0;
  int n_pass  = 0;
  int n_total = 0;
  logic [3:0] alu_tab [16] = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                               4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0};
  // {pc_load, ir_load, mem_read, mem_write, reg_write}
  logic [4:0] str_tab [16] = '{5'b00000, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001,
                               5'b00001, 5'b00101, 5'b00010, 5'b10000, 5'b10000, 5'b01100, 5'b00000, 5'b00000};
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic drive(input logic ce, input logic w, input logic r, input logic [23:0] a, input logic [7:0] d);
    bus.clk_enable = ce;
    bus.we         = w;
    bus.re         = r;
    bus.addr       = a;
    bus.din        = d;
  endtask
  task automatic step();
    int i;
    i = int'(bus.addr) % DEPTH;
    if (!reset) m_dout = 8'h00;
    else if (bus.clk_enable && bus.we) ref_mem[i] = bus.din;
    else if (bus.clk_enable && bus.re) m_dout = ref_mem[i];
    n_en = (reset && bus.lsi_enable) ? n_en + 1 : 0;
    @(posedge clk);
    #1;
    check("dout", 32'(bus.dout), 32'(m_dout));
    check("lsi_clk", 32'(bus.lsi_clk), 32'((n_en / LSI_DIV) % 2));
    check("wdt_clk", 32'(bus.wdt_clk), 32'(((n_en / LSI_DIV + 1) / 2 / WDT_DIV) % 2));
  endtask
  task automatic check_dec(input logic [3:0] op, input logic rst_n);
    bus.opcode = op;
    #1;
    check("alu_op", 32'(bus.alu_op), rst_n ? 32'(alu_tab[op]) : 32'h0);
    check("strobes", 32'({bus.pc_load, bus.ir_load, bus.mem_read, bus.mem_write, bus.reg_write}),
          rst_n ? 32'(str_tab[op]) : 32'h0);
  endtask
  initial begin
    logic [31:0] word;
    logic [23:0] a;
    word = 32'h0100_8113;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'hFF;
    bus.lsi_enable = 1'b0;
    bus.opcode     = 4'h0;
    drive(1'b0, 1'b0, 1'b0, 24'h0, 8'h0);
    step();
    step();
    check("reset_dout", 32'(bus.dout), 32'h0);
    for (int op = 0; op < 16; op++) check_dec(4'(op), 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, 24'(i), word[8*i +: 8]);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b1, 24'(i), 8'h0);
      step();
      check("read_le", 32'(bus.dout), 32'(word[8*i +: 8]));
    end
    drive(1'b1, 1'b0, 1'b1, 24'h000100, 8'h0);
    step();
    check("erased", 32'(bus.dout), 32'hFF);
    drive(1'b1, 1'b0, 1'b1, 24'(DEPTH + 1), 8'h0);
    step();
    check("wrap", 32'(bus.dout), 32'h81);
    drive(1'b0, 1'b1, 1'b0, 24'h0, 8'hAA);
    step();
    check("ce_off_hold", 32'(bus.dout), 32'h81);
    drive(1'b1, 1'b0, 1'b1, 24'h0, 8'h0);
    step();
    check("ce_off_nowrite", 32'(bus.dout), 32'h13);
    drive(1'b1, 1'b1, 1'b1, 24'h5, 8'h5A);
    step();
    check("we_re_hold", 32'(bus.dout), 32'h13);
    drive(1'b1, 1'b0, 1'b1, 24'h5, 8'h0);
    step();
    check("we_re_write", 32'(bus.dout), 32'h5A);
    drive(1'b1, 1'b1, 1'b0, 24'h7, 8'hC3);
    step();
    drive(1'b1, 1'b0, 1'b1, 24'h7, 8'h0);
    step();
    check("raw", 32'(bus.dout), 32'hC3);
    drive(1'b1, 1'b1, 1'b1, 24'h3, 8'h77);
    reset = 1'b0;
    step();
    check("reset_abort", 32'(bus.dout), 32'h0);
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 24'h3, 8'h0);
    step();
    check("retained", 32'(bus.dout), 32'h01);
    drive(1'b0, 1'b0, 1'b0, 24'h0, 8'h0);
    bus.lsi_enable = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i == 4) check("lsi_first", 32'(bus.lsi_clk), 32'h1);
      if (i == 12) check("wdt_first", 32'(bus.wdt_clk), 32'h1);
    end
    bus.lsi_enable = 1'b0;
    step();
    check("lsi_off", 32'({bus.lsi_clk, bus.wdt_clk}), 32'h0);
    for (int i = 0; i < 300; i++) begin
      a = 24'($urandom);
      a[11:0] = 12'($urandom_range(0, 15));
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0), 1'($urandom), a, 8'($urandom));
      bus.lsi_enable = 1'($urandom_range(0, 19) != 0);
      reset = 1'($urandom_range(0, 49) != 0);
      step();
    end
    reset = 1'b1;
    for (int op = 0; op < 16; op++) check_dec(4'(op), 1'b1);
    for (int i = 0; i < 20; i++) check_dec(4'($urandom), 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
